// File: rtl/n64_read_response.sv
// n64_read_response
// Decodes the N64 controller's serial reply into a parallel status word.
// Each bit is pulse-width coded and starts with a falling edge. The line is
// sampled SAMPLE_PT cycles after that edge: a high line is a 1, a low line is a 0.
// The bits arrive MSB first and are followed by the controller stop bit.
// Optional feature macro: N64_READ_SYNC_EN places a two-flop synchronizer
// (both flops reset high) between data_in and the edge detector.
module n64_read_response #(
    parameter int SAMPLE_PT = 200,
    parameter int TIMEOUT   = 1000,
    parameter int NUM_BITS  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        begin_read,
    input  logic        data_in,
    output logic        reading,
    output logic [31:0] response,
    output logic        data_valid,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        SAMPLE,
        WAIT_RISE,
        WAIT_STOP,
        STOP_LOW,
        DONE,
        ABORT
    } state_t;

    localparam logic [9:0] SampleLast = 10'(SAMPLE_PT - 1);
    localparam logic [9:0] TimeoutVal = 10'(TIMEOUT);
    localparam logic [5:0] BitsVal    = 6'(NUM_BITS);

    state_t      state_q;
    logic [9:0]  timer_q;
    logic [9:0]  timer_d;
    logic [5:0]  bitCount_q;
    logic [31:0] shift_q;
    logic [31:0] response_q;
    logic        reading_q;
    logic        dataValid_q;
    logic        timeoutErr_q;
    logic        line;
    logic        linePrev_q;
    logic        fall;
    logic        rise;
    logic        timedOut;

`ifdef N64_READ_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer; both stages reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;
`else
    assign line = data_in;
`endif

    // Previous line sample for edge detection; resets high like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            linePrev_q <= 1'b1;
        end else begin
            linePrev_q <= line;
        end
    end

    assign fall     = linePrev_q & ~line;
    assign rise     = ~linePrev_q & line;
    assign timedOut = (timer_q == TimeoutVal);

    // Saturating increment so a very long wait cannot wrap the timer back to zero.
    always_comb begin
        timer_d = timer_q;
        if (timer_q != 10'h3FF) begin
            timer_d = timer_q + 10'd1;
        end
    end

    // Receive FSM. The registered pulse outputs are cleared every cycle unless set below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bitCount_q   <= '0;
            shift_q      <= '0;
            response_q   <= '0;
            reading_q    <= 1'b0;
            dataValid_q  <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            dataValid_q  <= 1'b0;
            timeoutErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (begin_read) begin
                        state_q    <= WAIT_FALL;
                        reading_q  <= 1'b1;
                        bitCount_q <= '0;
                        timer_q    <= '0;
                        shift_q    <= '0;
                    end
                end
                WAIT_FALL: begin
                    if (fall) begin
                        timer_q <= '0;
                        state_q <= SAMPLE;
                    end else if (timedOut) begin
                        timer_q      <= '0;
                        state_q      <= ABORT;
                        timeoutErr_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                SAMPLE: begin
                    if (timer_q == SampleLast) begin
                        shift_q    <= {shift_q[30:0], line};
                        bitCount_q <= bitCount_q + 6'd1;
                        timer_q    <= '0;
                        state_q    <= WAIT_RISE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                WAIT_RISE: begin
                    if (line) begin
                        timer_q <= '0;
                        state_q <= (bitCount_q == BitsVal) ? WAIT_STOP : WAIT_FALL;
                    end else if (timedOut) begin
                        timer_q      <= '0;
                        state_q      <= ABORT;
                        timeoutErr_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                WAIT_STOP: begin
                    if (fall) begin
                        timer_q <= '0;
                        state_q <= STOP_LOW;
                    end else if (timedOut) begin
                        timer_q      <= '0;
                        state_q      <= ABORT;
                        timeoutErr_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                STOP_LOW: begin
                    if (rise) begin
                        timer_q     <= '0;
                        response_q  <= shift_q;
                        dataValid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (timedOut) begin
                        timer_q      <= '0;
                        state_q      <= ABORT;
                        timeoutErr_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DONE: begin
                    // data_valid is high this cycle; reading drops as IDLE is re-entered.
                    timer_q   <= '0;
                    reading_q <= 1'b0;
                    state_q   <= IDLE;
                end
                ABORT: begin
                    // timeout_err is high this cycle; response keeps its last good word.
                    timer_q   <= '0;
                    reading_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    timer_q   <= '0;
                    reading_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign reading     = reading_q;
    assign response    = response_q;
    assign data_valid  = dataValid_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_n64_read_response.sv
// tb_n64_read_response
// Drives pulse-width-coded controller replies into n64_read_response.
// Every word that is sent is pushed to an expected-word queue. A monitor pops
// that queue whenever data_valid pulses and compares the popped word.
module tb_n64_read_response;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        beginRead;
    logic        dataIn;
    logic        reading;
    logic [31:0] response;
    logic        dataValid;
    logic        timeoutErr;

    int          checkCount = 0;
    int          passCount  = 0;
    int          dvCount    = 0;
    int          toCount    = 0;
    logic [31:0] expQ[$];
    logic [31:0] expWord;
    logic [31:0] lastGood;

    n64_read_response dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .begin_read (beginRead),
        .data_in    (dataIn),
        .reading    (reading),
        .response   (response),
        .data_valid (dataValid),
        .timeout_err(timeoutErr)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Scoreboard monitor: samples 1 ns after each edge. The test tasks sample 2 ns after the edge, so they see updated counts.
    always @(posedge clk) begin
        #1;
        if (rst_n && dataValid) begin
            dvCount++;
            checkCount++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL scoreboard_unexpected: data_valid with response=%h, no word expected", response);
            end else begin
                expWord = expQ.pop_front();
                if (response !== expWord) begin
                    $display("[TB] FAIL scoreboard_word: response=%h, expected %h", response, expWord);
                end else begin
                    passCount++;
                end
            end
        end
        if (rst_n && timeoutErr) begin
            toCount++;
        end
    end

    // Watchdog keeps the run bounded even if the DUT stalls a wait loop.
    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic lvl, input int n);
        dataIn = lvl;
        repeat (n) tick();
    endtask

    task automatic start_read();
        beginRead = 1'b1;
        tick();
        beginRead = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int jit);
        int j1;
        int j2;
        j1 = 0;
        j2 = 0;
        if (jit > 0) begin
            j1 = int'($urandom_range(2 * jit, 0)) - jit;
            j2 = int'($urandom_range(2 * jit, 0)) - jit;
        end
        if (b) begin
            hold(1'b0, 100 + j1);
            hold(1'b1, 300 + j2);
        end else begin
            hold(1'b0, 300 + j1);
            hold(1'b1, 100 + j2);
        end
    endtask

    // Sends bits first..last-1 of w, counting from the MSB.
    task automatic send_bits(input logic [31:0] w, input int first, input int last, input int jit);
        logic [31:0] word;
        word = w;
        for (int i = first; i < last; i++) begin
            send_bit(word[31 - i], jit);
        end
    endtask

    // Stop bit: 1 us low, then high. Returns the number of ticks until data_valid is seen, or -1 if it never is.
    task automatic send_stop_wait(output int lat);
        hold(1'b0, 100);
        dataIn = 1'b1;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (dataValid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        beginRead = 1'b0;
        dataIn    = 1'b1;
        repeat (3) tick();
        checkCount++;
        if (reading !== 1'b0) $display("[TB] FAIL reset_reading: got %b, expected 0", reading);
        else passCount++;
        checkCount++;
        if (response !== 32'h0) $display("[TB] FAIL reset_response: got %h, expected 00000000", response);
        else passCount++;
        checkCount++;
        if (dataValid !== 1'b0) $display("[TB] FAIL reset_data_valid: got %b, expected 0", dataValid);
        else passCount++;
        checkCount++;
        if (timeoutErr !== 1'b0) $display("[TB] FAIL reset_timeout_err: got %b, expected 0", timeoutErr);
        else passCount++;
        rst_n = 1'b1;
        hold(1'b1, 5);
        lastGood = 32'h0;
    endtask

    task automatic test_single_msb();
        int startDv;
        int startTo;
        int lat;
        startDv = dvCount;
        startTo = toCount;
        expQ.push_back(32'h8000_0000);
        start_read();
        checkCount++;
        if (reading !== 1'b1) $display("[TB] FAIL msb_reading_set: got %b, expected 1", reading);
        else passCount++;
        send_bits(32'h8000_0000, 0, 32, 0);
        send_stop_wait(lat);
        checkCount++;
        if (lat !== 1) $display("[TB] FAIL msb_dv_latency: got %0d ticks, expected 1", lat);
        else passCount++;
        hold(1'b1, 20);
        checkCount++;
        if (dvCount !== startDv + 1) $display("[TB] FAIL msb_dv_count: got %0d pulses, expected 1", dvCount - startDv);
        else passCount++;
        checkCount++;
        if (toCount !== startTo) $display("[TB] FAIL msb_no_timeout: got %0d pulses, expected 0", toCount - startTo);
        else passCount++;
        lastGood = 32'h8000_0000;
    endtask

    task automatic test_jitter();
        int lat;
        expQ.push_back(32'hA5A5_0F0F);
        start_read();
        send_bits(32'hA5A5_0F0F, 0, 32, 10);
        send_stop_wait(lat);
        checkCount++;
        if (lat !== 1) $display("[TB] FAIL jitter_dv_latency: got %0d ticks, expected 1", lat);
        else passCount++;
        checkCount++;
        if (reading !== 1'b1) $display("[TB] FAIL jitter_reading_at_dv: got %b, expected 1", reading);
        else passCount++;
        // A begin_read in the data_valid cycle must be ignored.
        beginRead = 1'b1;
        tick();
        beginRead = 1'b0;
        checkCount++;
        if (reading !== 1'b0) $display("[TB] FAIL jitter_reading_fall: got %b, expected 0", reading);
        else passCount++;
        checkCount++;
        if (dataValid !== 1'b0) $display("[TB] FAIL jitter_dv_width: got %b, expected 0", dataValid);
        else passCount++;
        tick();
        checkCount++;
        if (reading !== 1'b0) $display("[TB] FAIL jitter_begin_ignored: reading got %b, expected 0", reading);
        else passCount++;
        hold(1'b1, 10);
        lastGood = 32'hA5A5_0F0F;
    endtask

    task automatic test_timeout();
        int startDv;
        int startTo;
        int n;
        logic rdAt;
        logic rdAfter;
        startDv = dvCount;
        startTo = toCount;
        n       = 0;
        rdAt    = 1'bx;
        rdAfter = 1'bx;
        dataIn  = 1'b1;
        start_read();
        for (int i = 1; i <= 1200; i++) begin
            tick();
            if (timeoutErr && n == 0) begin
                n    = i;
                rdAt = reading;
            end else if (n != 0 && i == n + 1) begin
                rdAfter = reading;
            end
        end
        checkCount++;
        if (n !== 1001) $display("[TB] FAIL timeout_cycle: got pulse at cycle %0d, expected 1001", n);
        else passCount++;
        checkCount++;
        if (rdAt !== 1'b1) $display("[TB] FAIL timeout_reading_at_pulse: got %b, expected 1", rdAt);
        else passCount++;
        checkCount++;
        if (rdAfter !== 1'b0) $display("[TB] FAIL timeout_reading_after: got %b, expected 0", rdAfter);
        else passCount++;
        checkCount++;
        if (toCount !== startTo + 1) $display("[TB] FAIL timeout_pulse_count: got %0d, expected 1", toCount - startTo);
        else passCount++;
        checkCount++;
        if (response !== lastGood) $display("[TB] FAIL timeout_response_kept: got %h, expected %h", response, lastGood);
        else passCount++;
        checkCount++;
        if (dvCount !== startDv) $display("[TB] FAIL timeout_no_dv: got %0d pulses, expected 0", dvCount - startDv);
        else passCount++;
    endtask

    task automatic test_stuck_low();
        int startDv;
        int startTo;
        int seen;
        startDv = dvCount;
        startTo = toCount;
        seen    = 0;
        start_read();
        send_bits(32'hFFF0_0000, 0, 12, 0);
        dataIn = 1'b0;
        for (int i = 1; i <= 1500; i++) begin
            tick();
            if (timeoutErr) begin
                seen = i;
                break;
            end
        end
        checkCount++;
        if (seen == 0) $display("[TB] FAIL stuck_timeout_seen: got no pulse within 1500 cycles, expected a pulse");
        else passCount++;
        hold(1'b1, 20);
        checkCount++;
        if (toCount !== startTo + 1) $display("[TB] FAIL stuck_pulse_count: got %0d, expected 1", toCount - startTo);
        else passCount++;
        checkCount++;
        if (dvCount !== startDv) $display("[TB] FAIL stuck_no_dv: got %0d pulses, expected 0", dvCount - startDv);
        else passCount++;
        checkCount++;
        if (response !== lastGood) $display("[TB] FAIL stuck_response_kept: got %h, expected %h", response, lastGood);
        else passCount++;
        checkCount++;
        if (reading !== 1'b0) $display("[TB] FAIL stuck_reading: got %b, expected 0", reading);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int startDv;
        int lat;
        startDv = dvCount;
        expQ.push_back(32'h1234_5678);
        start_read();
        send_bits(32'h1234_5678, 0, 16, 0);
        // A second arm strobe mid-word must be ignored.
        beginRead = 1'b1;
        tick();
        beginRead = 1'b0;
        checkCount++;
        if (reading !== 1'b1) $display("[TB] FAIL b2b_reading_mid: got %b, expected 1", reading);
        else passCount++;
        send_bits(32'h1234_5678, 16, 32, 0);
        send_stop_wait(lat);
        checkCount++;
        if (lat !== 1) $display("[TB] FAIL b2b_dv_latency: got %0d ticks, expected 1", lat);
        else passCount++;
        hold(1'b1, 20);
        checkCount++;
        if (dvCount !== startDv + 1) $display("[TB] FAIL b2b_dv_count: got %0d pulses, expected 1", dvCount - startDv);
        else passCount++;
        checkCount++;
        if (reading !== 1'b0) $display("[TB] FAIL b2b_reading_end: got %b, expected 0", reading);
        else passCount++;
        lastGood = 32'h1234_5678;
    endtask

    task automatic test_reset_mid();
        int startDv;
        int startTo;
        int lat;
        startDv = dvCount;
        startTo = toCount;
        start_read();
        send_bits(32'hFFFF_FFFF, 0, 20, 0);
        hold(1'b0, 50);
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (reading !== 1'b0) $display("[TB] FAIL rstmid_reading: got %b, expected 0", reading);
        else passCount++;
        checkCount++;
        if (response !== 32'h0) $display("[TB] FAIL rstmid_response: got %h, expected 00000000", response);
        else passCount++;
        checkCount++;
        if (dataValid !== 1'b0 || timeoutErr !== 1'b0) $display("[TB] FAIL rstmid_pulses: got dv=%b to=%b, expected 0 0", dataValid, timeoutErr);
        else passCount++;
        dataIn = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        hold(1'b1, 10);
        lastGood = 32'h0;
        checkCount++;
        if (dvCount !== startDv || toCount !== startTo) $display("[TB] FAIL rstmid_no_pulse: got dv=%0d to=%0d, expected 0 0", dvCount - startDv, toCount - startTo);
        else passCount++;
        expQ.push_back(32'h0000_0001);
        start_read();
        send_bits(32'h0000_0001, 0, 32, 0);
        send_stop_wait(lat);
        checkCount++;
        if (lat !== 1) $display("[TB] FAIL rstmid_dv_latency: got %0d ticks, expected 1", lat);
        else passCount++;
        hold(1'b1, 20);
        checkCount++;
        if (dvCount !== startDv + 1) $display("[TB] FAIL rstmid_dv_count: got %0d pulses, expected 1", dvCount - startDv);
        else passCount++;
        lastGood = 32'h0000_0001;
    endtask

    initial begin
        rst_n     = 1'b0;
        beginRead = 1'b0;
        dataIn    = 1'b1;
        lastGood  = 32'h0;
        test_reset();
        test_single_msb();
        test_jitter();
        test_timeout();
        test_stuck_low();
        test_back_to_back();
        test_reset_mid();
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d words outstanding, expected 0", expQ.size());
        else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
